pc_sequencer: RTL and testbench

//   Program-counter stage directly upstream of instruction fetch. Holds the architectural PC and

---
 rtl/pc_pkg.sv | 8 +
 rtl/ret_addr_stack.sv | 36 +++
 rtl/pc_sequencer.sv | 66 ++++++
 tb/tb_pc_sequencer.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM encoding, PC step size and address-wrap helper for pc_sequencer.
package pc_pkg;
  typedef enum logic [1:0] {PC_BOOT = 2'd0, PC_RUN = 2'd1, PC_HALT = 2'd2} pc_state_e;
  localparam logic [31:0] PC_STEP = 32'd4;
  function automatic logic [31:0] pc_wrap(input logic [31:0] addr, input logic [31:0] mem_bytes);
    return addr % mem_bytes;
  endfunction
endpackage

// File: rtl/ret_addr_stack.sv
// ret_addr_stack: circular return-address stack; a push when full overwrites the oldest entry.
module ret_addr_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic [31:0] top,
  output logic        empty,
  output logic        full
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] ptr, ptr_up, ptr_dn;
  logic [AW:0] cnt;
  assign ptr_up = ptr == AW'(DEPTH - 1) ? '0 : ptr + 1'b1;
  assign ptr_dn = ptr == '0 ? AW'(DEPTH - 1) : ptr - 1'b1;
  assign top = mem[ptr];
  assign empty = cnt == '0;
  assign full = cnt == (AW + 1)'(DEPTH);
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
    end else if (push) begin
      mem[ptr_up] <= din;
      ptr <= ptr_up;
      if (!full) cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr_dn;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC stage feeding fetch (boot/run/halt, redirects, stall); PC_RAS_EN adds a return-address stack.
module pc_sequencer import pc_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'd20,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        redirect_is_call,
  input  logic        redirect_is_ret,
  input  logic        halt_req,
  output logic [31:0] PC,
  output logic        pc_valid,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] instr_count
);
  pc_state_e state, state_n;
  logic [31:0] pc_n, pc_inc, tgt, ras_top;
  logic take, pop;
  assign pc_inc = (PC + PC_STEP >= MEM_BYTES) ? '0 : PC + PC_STEP;
  assign tgt = pc_wrap({redirect_target[31:2], 2'b00}, MEM_BYTES);
  assign take = state == PC_RUN && !halt_req && redirect_valid;
`ifdef PC_RAS_EN
  logic push, ras_empty, unused_full;
  assign push = take && redirect_is_call;
  assign pop = take && redirect_is_ret && !redirect_is_call && !ras_empty;
  ret_addr_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(pc_inc),
    .top(ras_top), .empty(ras_empty), .full(unused_full)
  );
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, redirect_is_call, redirect_is_ret, RAS_DEPTH != 0};
  assign pop = 1'b0;
  assign ras_top = '0;
`endif
  assign pc_valid = state == PC_RUN;
  assign halted = state == PC_HALT;
  always_comb begin
    state_n = state;
    pc_n = PC;
    if (state == PC_BOOT) state_n = PC_RUN;
    else if (state == PC_RUN) begin
      if (halt_req) state_n = PC_HALT;
      else if (redirect_valid) pc_n = pop ? ras_top : tgt;
      else if (!stall) pc_n = pc_inc;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PC_BOOT;
      PC <= RESET_PC;
      misalign <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      PC <= pc_n;
      misalign <= misalign | (take & ~pop & |redirect_target[1:0]);
      if (state == PC_RUN && !stall) instr_count <= instr_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, hand-written corner sequences and a random run against a queue-based model.
module tb_pc_sequencer;
  localparam logic [31:0] MEM = 32'd20;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset, stall, redirect_valid, redirect_is_call, redirect_is_ret, halt_req;
  logic [31:0] redirect_target, PC, instr_count;
  logic pc_valid, halted, misalign;
  int checks = 0, fails = 0;
  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .redirect_is_call(redirect_is_call),
    .redirect_is_ret(redirect_is_ret), .halt_req(halt_req), .PC(PC), .pc_valid(pc_valid),
    .halted(halted), .misalign(misalign), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, st, rv, h;
    logic [31:0] t;
    logic [31:0] pc;
    logic v, hl, mis;
    logic [31:0] cnt;
  } vec_t;
  vec_t vecs[30];
  int m_mode;
  logic [31:0] m_pc, m_cnt;
  bit m_mis;
  logic [31:0] m_ras[$];
  function automatic vec_t mk(input logic r, st, rv, h, input logic [31:0] t, pc,
                              input logic v, hl, mis, input logic [31:0] cnt);
    vec_t x;
    x.r = r; x.st = st; x.rv = rv; x.h = h; x.t = t;
    x.pc = pc; x.v = v; x.hl = hl; x.mis = mis; x.cnt = cnt;
    return x;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input bit r, st, rv, ca, re, h, input logic [31:0] t);
    reset = r; stall = st; redirect_valid = rv; redirect_is_call = ca;
    redirect_is_ret = re; halt_req = h; redirect_target = t;
  endtask
  task automatic model(input bit r, st, rv, ca, re, h, input logic [31:0] t);
    bit is_call, is_ret;
    is_call = ca;
    is_ret = re & ~ca;
`ifndef PC_RAS_EN
    is_call = 0;
    is_ret = 0;
`endif
    if (r) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_mis = 0; m_ras.delete();
    end else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (!st) m_cnt++;
      if (h) m_mode = 2;
      else if (rv && is_ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
      else if (rv) begin
        if (is_call) begin
          m_ras.push_back((m_pc + 4) % MEM);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
        if (t % 4 != 0) m_mis = 1;
        m_pc = ((t / 4) * 4) % MEM;
      end else if (!st) m_pc = (m_pc + 4) % MEM;
    end
  endtask
  task automatic cyc(input bit r, st, rv, ca, re, h, input logic [31:0] t, input string tag);
    drive(r, st, rv, ca, re, h, t);
    @(posedge clk);
    #1;
    model(r, st, rv, ca, re, h, t);
    chk({tag, "/pc"}, PC, m_pc);
    chk({tag, "/valid"}, pc_valid, m_mode == 1);
    chk({tag, "/halted"}, halted, m_mode == 2);
    chk({tag, "/misalign"}, misalign, m_mis);
    chk({tag, "/count"}, instr_count, m_cnt);
  endtask
  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    vecs[0]  = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,     0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,     4, 1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 0, 0,     8, 1, 0, 0, 2);
    vecs[4]  = mk(0, 0, 0, 0, 0,    12, 1, 0, 0, 3);
    vecs[5]  = mk(0, 0, 0, 0, 0,    16, 1, 0, 0, 4);
    vecs[6]  = mk(0, 0, 0, 0, 0,     0, 1, 0, 0, 5);
    vecs[7]  = mk(0, 0, 0, 0, 0,     4, 1, 0, 0, 6);
    vecs[8]  = mk(0, 0, 0, 0, 0,     8, 1, 0, 0, 7);
    vecs[9]  = mk(0, 1, 0, 0, 0,     8, 1, 0, 0, 7);
    vecs[10] = mk(0, 1, 0, 0, 0,     8, 1, 0, 0, 7);
    vecs[11] = mk(0, 1, 0, 0, 0,     8, 1, 0, 0, 7);
    vecs[12] = mk(0, 1, 1, 0, 4,     4, 1, 0, 0, 7);
    vecs[13] = mk(0, 0, 0, 0, 0,     8, 1, 0, 0, 8);
    vecs[14] = mk(0, 0, 1, 0, 32'hE, 12, 1, 0, 1, 9);
    vecs[15] = mk(0, 0, 0, 0, 0,    16, 1, 0, 1, 10);
    vecs[16] = mk(0, 0, 0, 0, 0,     0, 1, 0, 1, 11);
    vecs[17] = mk(0, 0, 0, 0, 0,     4, 1, 0, 1, 12);
    vecs[18] = mk(0, 0, 0, 0, 0,     8, 1, 0, 1, 13);
    vecs[19] = mk(0, 0, 0, 0, 0,    12, 1, 0, 1, 14);
    vecs[20] = mk(0, 0, 1, 1, 0,    12, 0, 1, 1, 15);
    vecs[21] = mk(0, 1, 1, 0, 4,    12, 0, 1, 1, 15);
    vecs[22] = mk(0, 0, 0, 0, 0,    12, 0, 1, 1, 15);
    vecs[23] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 0, 0,     0, 1, 0, 0, 0);
    vecs[25] = mk(0, 0, 1, 0, 24,    4, 1, 0, 0, 1);
    vecs[26] = mk(0, 0, 1, 0, 20,    0, 1, 0, 0, 2);
    vecs[27] = mk(1, 0, 0, 0, 0,     0, 0, 0, 0, 0);
    vecs[28] = mk(0, 0, 0, 1, 0,     0, 1, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 0, 0,     4, 1, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      drive(vecs[i].r, vecs[i].st, vecs[i].rv, 0, 0, vecs[i].h, vecs[i].t);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d/pc", i), PC, vecs[i].pc);
      chk($sformatf("vec%0d/valid", i), pc_valid, vecs[i].v);
      chk($sformatf("vec%0d/halted", i), halted, vecs[i].hl);
      chk($sformatf("vec%0d/misalign", i), misalign, vecs[i].mis);
      chk($sformatf("vec%0d/count", i), instr_count, vecs[i].cnt);
    end
`ifdef PC_RAS_EN
    cyc(1, 0, 0, 0, 0, 0, 0, "ras_rst");
    cyc(0, 0, 0, 0, 0, 0, 0, "ras_boot");
    cyc(0, 0, 0, 0, 0, 0, 0, "ras_step");
    chk("ras_start_pc", PC, 4);
    cyc(0, 0, 1, 1, 0, 0, 16, "ras_call");
    chk("ras_call_pc", PC, 16);
    cyc(0, 0, 1, 0, 1, 0, 0, "ras_ret");
    chk("ras_ret_pc", PC, 8);
    cyc(0, 0, 1, 0, 1, 0, 12, "ras_ret_empty");
    chk("ras_ret_empty_pc", PC, 12);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0, i * 4, "ras_call5");
    cyc(0, 0, 1, 0, 1, 0, 0, "ras_pop1");
    chk("ras_pop1_pc", PC, 16);
    cyc(0, 0, 1, 0, 1, 0, 0, "ras_pop2");
    chk("ras_pop2_pc", PC, 12);
    cyc(0, 0, 1, 0, 1, 0, 0, "ras_pop3");
    chk("ras_pop3_pc", PC, 8);
    cyc(0, 0, 1, 0, 1, 0, 0, "ras_pop4");
    chk("ras_pop4_pc", PC, 4);
    cyc(0, 0, 1, 0, 1, 0, 0, "ras_pop5_empty");
    chk("ras_pop5_pc", PC, 0);
`endif
    cyc(1, 0, 0, 0, 0, 0, 0, "rr_rst");
    cyc(0, 0, 0, 0, 0, 0, 0, "rr_boot");
    cyc(0, 0, 1, 1, 0, 0, 16, "rr_call");
    cyc(1, 0, 1, 0, 0, 0, 8, "rr_reset_redirect");
    chk("rr_pc", PC, 0);
    chk("rr_count", instr_count, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, "rr_boot2");
    cyc(0, 0, 1, 0, 1, 0, 12, "rr_ret_empty");
    chk("rr_ret_pc", PC, 12);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 39) == 0,
          $urandom_range(0, 31), "rand");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
